// File: rtl/group_sel_scheduler_if.sv
// group_sel_scheduler_if: manual slot-jump request handshake
// req_valid : request present (master -> slave)
// req_slot  : requested slot index (master -> slave)
// req_ready : request may be accepted this cycle (slave -> master)
interface group_sel_scheduler_if #(parameter int SEL_W = 4);
    logic             req_valid;
    logic [SEL_W-1:0] req_slot;
    logic             req_ready;
    modport master (output req_valid, req_slot, input req_ready);
    modport slave  (input req_valid, req_slot, output req_ready);
endinterface

// File: rtl/group_sel_scheduler.sv
// group_sel_scheduler: round-robin / manual project-select sequencer for the group output mux
// clk, rst    : clock, asynchronous active-high reset
// ena         : scheduler enable, 0 forces IDLE
// mask        : per-slot schedulable enables
// dwell       : cycles per slot in auto mode (0 behaves as 1)
// manual      : 1 disables auto advance
// req         : slot-jump request handshake (slave side)
// sel         : registered mux select
// sel_valid   : sel is stable and owned by an enabled slot
// switch_stb  : one-cycle pulse when a new sel is presented
// blank       : mux output must be forced to 0
// err_stb     : accepted request targeted a masked slot
// Optional macro GROUP_SCHED_BLANK_EN: guard phase of BLANK_CYCLES with blank=1 on every switch.
module group_sel_scheduler #(
    parameter int NUM_SLOTS    = 16,
    parameter int SEL_W        = 4,
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 manual,
    group_sel_scheduler_if.slave req,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 switch_stb,
    output logic                 blank,
    output logic                 err_stb
);
`ifdef GROUP_SCHED_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int BL = BLANK_CYCLES < 1 ? 1 : BLANK_CYCLES;

    typedef enum logic [1:0] {IDLE, SWITCH, DWELL} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n, first, nxt, tgt;
    logic [DWELL_W-1:0] cnt, cnt_n, cnt_inc, dwell_m1;
    logic               stb_n, err_n, accept, expire;

    // counter saturates so a long manual hold never wraps into a false expiry
    assign cnt_inc       = &cnt ? cnt : cnt + 1'b1;
    assign dwell_m1      = dwell == '0 ? '0 : dwell - 1'b1;
    assign expire        = !manual && cnt >= dwell_m1;
    assign accept        = req.req_valid && state == DWELL;
    assign tgt           = accept ? req.req_slot : nxt;
    assign req.req_ready = state == DWELL;
    assign sel_valid     = state == DWELL || (state == SWITCH && !BLANK_EN);
    assign blank         = BLANK_EN && state == SWITCH;

    // descending scans: the last hit is the lowest bit / nearest slot after sel
    always_comb begin
        first = '0;
        nxt   = sel;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (mask[i]) first = SEL_W'(i);
        for (int i = NUM_SLOTS; i >= 1; i--)
            if (mask[sel + SEL_W'(i)]) nxt = sel + SEL_W'(i);
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        if (!ena)
            state_n = IDLE;
        else case (state)
            IDLE: if (|mask) begin
                state_n = SWITCH;
                sel_n   = first;
                cnt_n   = '0;
                stb_n   = !BLANK_EN;
            end
            SWITCH: if (!BLANK_EN || cnt == DWELL_W'(BL - 1)) begin
                state_n = DWELL;
                cnt_n   = '0;
                stb_n   = BLANK_EN;
            end else
                cnt_n = cnt_inc;
            default: begin
                cnt_n = cnt_inc;
                if (mask == '0)
                    state_n = IDLE;
                else if (accept && !mask[req.req_slot])
                    err_n = 1'b1;
                else if (accept || !mask[sel] || expire) begin
                    cnt_n = '0;
                    if (tgt != sel) begin
                        state_n = SWITCH;
                        sel_n   = tgt;
                        stb_n   = !BLANK_EN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            switch_stb <= 1'b0;
            err_stb    <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            switch_stb <= stb_n;
            err_stb    <= err_n;
        end
endmodule

// File: tb/tb_group_sel_scheduler.sv
// tb_group_sel_scheduler: self-checking bench with a slot-level reference model
module tb_group_sel_scheduler;
`ifdef GROUP_SCHED_BLANK_EN
    localparam bit BLANK = 1'b1;
    localparam int SWLEN = 2;
`else
    localparam bit BLANK = 1'b0;
    localparam int SWLEN = 1;
`endif
    localparam int PER = 3 + SWLEN;

    logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, manual = 1'b0;
    logic [15:0] mask = '0, dwell = '0;
    logic [3:0]  sel;
    logic        sel_valid, switch_stb, blank, err_stb;

    group_sel_scheduler_if #(.SEL_W(4)) rif();

    group_sel_scheduler #(.NUM_SLOTS(16), .SEL_W(4), .DWELL_W(16), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mask(mask), .dwell(dwell), .manual(manual),
        .req(rif), .sel(sel), .sel_valid(sel_valid), .switch_stb(switch_stb),
        .blank(blank), .err_stb(err_stb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = idle, 1 = switching (guard), 2 = showing a slot; age = cycles already shown
    int m_sel = 0, m_ph = 0, m_sw = 0, m_age = 0;
    bit m_stb = 0, m_err = 0;
    int dest;

    function automatic int after(int s, logic [15:0] m);
        for (int k = 1; k <= 16; k++)
            if (m[(s + k) % 16]) return (s + k) % 16;
        return s;
    endfunction

    function automatic void present(int s);
        m_sel = s;
        m_ph  = 1;
        m_sw  = 0;
        m_stb = !BLANK;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel = 0; m_ph = 0; m_sw = 0; m_age = 0; m_stb = 0; m_err = 0;
        end else begin
            m_stb = 0;
            m_err = 0;
            if (!ena) m_ph = 0;
            else if (m_ph == 0) begin
                if (mask != 0) present(after(15, mask));
            end else if (m_ph == 1) begin
                m_sw++;
                if (m_sw >= SWLEN) begin m_ph = 2; m_age = 0; m_stb = BLANK; end
            end else if (mask == 0) m_ph = 0;
            else begin
                if (rif.req_valid) begin
                    if (!mask[rif.req_slot]) dest = -1;
                    else dest = int'(rif.req_slot);
                end else if (!mask[m_sel] || (!manual && m_age + 1 >= (dwell == 0 ? 1 : int'(dwell))))
                    dest = after(m_sel, mask);
                else dest = -2;
                if (dest == -1) begin m_err = 1; m_age = m_age < 65535 ? m_age + 1 : m_age; end
                else if (dest == -2) m_age = m_age < 65535 ? m_age + 1 : m_age;
                else if (dest == m_sel) m_age = 0;
                else present(dest);
            end
        end
    end

    int cyc = 0, n_stb = 0;
    int stb_s[64], stb_c[64];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        chk("sel", sel, m_sel);
        chk("sel_valid", sel_valid, (m_ph == 2 || (m_ph == 1 && !BLANK)) ? 1 : 0);
        chk("blank", blank, (BLANK && m_ph == 1) ? 1 : 0);
        chk("req_ready", rif.req_ready, m_ph == 2 ? 1 : 0);
        chk("switch_stb", switch_stb, m_stb);
        chk("err_stb", err_stb, m_err);
        if (switch_stb && n_stb < 64) begin
            stb_s[n_stb] = sel;
            stb_c[n_stb] = cyc;
            n_stb++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_model(int ph, int age);
        for (int i = 0; i < 40; i++) begin
            if (m_ph == ph && m_age == age) return;
            @(negedge clk);
        end
        chk("wait_timeout", 0, 1);
    endtask

    initial begin
        rif.req_valid = 1'b0;
        rif.req_slot  = '0;
        tick(2);
        chk("rst_sel", sel, 0);
        chk("rst_valid", sel_valid, 0);
        chk("rst_ready", rif.req_ready, 0);
        rst = 1'b0;
        tick(2);
        chk("idle_valid", sel_valid, 0);

        mask = 16'h0092; dwell = 3; ena = 1'b1; n_stb = 0;
        tick(22);
        chk("rot0", stb_s[0], 1);
        chk("rot1", stb_s[1], 4);
        chk("rot2", stb_s[2], 7);
        chk("rot3", stb_s[3], 1);
        chk("rot_period", stb_c[2] - stb_c[1], PER);

        ena = 1'b0; tick(1);
        mask = 16'h0010; dwell = 2; ena = 1'b1; n_stb = 0;
        tick(12);
        chk("single_stb_count", n_stb, 1);
        chk("single_sel", sel, 4);

        ena = 1'b0; tick(1);
        mask = 16'h0212; dwell = 3; ena = 1'b1;
        wait_model(2, 2);
        chk("pre_req_sel", sel, 1);
        rif.req_valid = 1'b1; rif.req_slot = 4'd9;
        tick(1);
        rif.req_valid = 1'b0;
        chk("req_wins", sel, 9);
        chk("req_wins_stb", switch_stb, BLANK ? 0 : 1);

        wait_model(2, 0);
        chk("pre_err_sel", sel, 9);
        rif.req_valid = 1'b1; rif.req_slot = 4'd3;
        tick(1);
        rif.req_valid = 1'b0;
        chk("err_stb_hi", err_stb, 1);
        chk("err_sel", sel, 9);
        tick(1);
        chk("err_stb_lo", err_stb, 0);

        manual = 1'b1;
        tick(10);
        chk("manual_hold", sel, 9);
        rif.req_valid = 1'b1; rif.req_slot = 4'd9;
        tick(1);
        rif.req_valid = 1'b0;
        chk("same_req_stb", switch_stb, 0);
        chk("same_req_sel", sel, 9);
        rif.req_valid = 1'b1; rif.req_slot = 4'd4;
        tick(1);
        rif.req_valid = 1'b0;
        chk("manual_jump", sel, 4);
        manual = 1'b0;

        wait_model(2, 0);
        mask = 16'h0202;
        tick(1);
        chk("mask_clear_adv", sel, 9);

        mask = 16'h0003; dwell = 0;
        tick(12);
        wait_model(2, 0);
        mask = 16'h0000;
        tick(1);
        chk("mask_zero_valid", sel_valid, 0);
        chk("mask_zero_ready", rif.req_ready, 0);

        mask = 16'h0092; dwell = 3;
        tick(6);
        ena = 1'b0;
        tick(1);
        chk("ena_off_valid", sel_valid, 0);
        chk("ena_off_blank", blank, 0);

        mask = 16'h0020; ena = 1'b1;
        wait_model(2, 1);
        chk("pre_rst_sel", sel, 5);
        rst = 1'b1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_valid", sel_valid, 0);
        chk("arst_stb", switch_stb, 0);
        chk("arst_blank", blank, 0);
        chk("arst_ready", rif.req_ready, 0);
        chk("arst_err", err_stb, 0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", sel_valid, 0);
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
